// File: rtl/target_pkg.sv
// Shared types and default constants for the target slew limiter.
package target_pkg;

  localparam int SP_W = 16;

  typedef logic signed [SP_W-1:0] sp_t;

  localparam int DEF_TICK_DIV      = 50000;
  localparam int DEF_ATT_STEP      = 64;
  localparam int DEF_HGT_STEP      = 16;
  localparam int DEF_TIMEOUT_TICKS = 500;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_HEIGHT = 2'd0,
    CH_PITCH  = 2'd1,
    CH_ROLL   = 2'd2,
    CH_YAW    = 2'd3
  } chan_e;

endpackage

// File: rtl/target_slew_channel.sv
// One setpoint channel: latched goal plus a setpoint that walks toward it by
// at most STEP per control tick.
module target_slew_channel
  import target_pkg::*;
#(
  parameter int STEP = DEF_ATT_STEP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic signed [SP_W-1:0] load_val,
  input  logic                   force_zero,
  input  logic                   tick,
  output logic signed [SP_W-1:0] sp,
  output logic                   at_goal
);

  // 17-bit copy for the distance test, 16-bit copy for the actual step; the
  // stepped result always lies between sp and goal so 16 bits cannot wrap.
  localparam logic signed [SP_W:0]   STEP_W = (SP_W+1)'(STEP);
  localparam logic signed [SP_W-1:0] STEP_N = SP_W'(STEP);

  sp_t                 goal_q;
  sp_t                 goal_nx;
  sp_t                 sp_nx;
  logic signed [SP_W:0] diff;
  logic signed [SP_W:0] mag;

  // Next goal: a fresh command beats the watchdog override.
  always_comb begin
    goal_nx = goal_q;
    if (load) begin
      goal_nx = load_val;
    end else if (force_zero) begin
      goal_nx = '0;
    end
  end

  // Next setpoint: the tick always ramps against the goal held before this edge.
  always_comb begin
    diff  = {goal_q[SP_W-1], goal_q} - {sp[SP_W-1], sp};
    mag   = diff[SP_W] ? -diff : diff;
    sp_nx = sp;
    if (tick) begin
      if (mag <= STEP_W) begin
        sp_nx = goal_q;
      end else if (!diff[SP_W]) begin
        sp_nx = sp + STEP_N;
      end else begin
        sp_nx = sp - STEP_N;
      end
    end
  end

  // Goal/setpoint registers; at_goal is judged on next-state values so it
  // lines up with the cycle the new setpoint becomes visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      goal_q  <= '0;
      sp      <= '0;
      at_goal <= 1'b1;
    end else begin
      goal_q  <= goal_nx;
      sp      <= sp_nx;
      at_goal <= (sp_nx == goal_nx);
    end
  end

endmodule

// File: rtl/target_slew_limiter.sv
// Rate-limits the decoded flight targets before they reach the PID loops and
// drives all goals to zero when the command link goes quiet.
module target_slew_limiter
  import target_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int ATT_STEP      = DEF_ATT_STEP,
  parameter int HGT_STEP      = DEF_HGT_STEP,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   target_renew,
  input  logic signed [SP_W-1:0] target_height,
  input  logic signed [SP_W-1:0] target_pitch,
  input  logic signed [SP_W-1:0] target_roll,
  input  logic signed [SP_W-1:0] target_yaw,
  output logic                   sp_valid,
  output logic signed [SP_W-1:0] sp_height,
  output logic signed [SP_W-1:0] sp_pitch,
  output logic signed [SP_W-1:0] sp_roll,
  output logic signed [SP_W-1:0] sp_yaw,
  output logic                   failsafe,
  output logic                   sp_settled
);

  localparam int TC_W = $clog2(TICK_DIV + 1);
  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TC_W-1:0]   tick_cnt;
  logic              tick;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expire;
  logic [NUM_CH-1:0] at_goal;

  assign tick       = (tick_cnt == TC_W'(TICK_DIV - 1));
  // Only a tick that is not accompanied by a renew can push the watchdog over.
  assign wd_expire  = tick && !target_renew && (wd_cnt == WD_W'(TIMEOUT_TICKS - 1));
  assign sp_settled = &at_goal;

  // Control tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TC_W'(1);
    end
  end

  // Link-loss watchdog: counts silent ticks, saturates, and latches failsafe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      failsafe <= 1'b0;
    end else if (target_renew) begin
      wd_cnt   <= '0;
      failsafe <= 1'b0;
    end else if (tick && (wd_cnt != WD_W'(TIMEOUT_TICKS))) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expire) begin
        failsafe <= 1'b1;
      end
    end
  end

  // sp_valid marks the first cycle the post-tick setpoints are visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_valid <= 1'b0;
    end else begin
      sp_valid <= tick;
    end
  end

  target_slew_channel #(.STEP(HGT_STEP)) u_height (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (target_renew),
    .load_val   (target_height),
    .force_zero (wd_expire),
    .tick       (tick),
    .sp         (sp_height),
    .at_goal    (at_goal[CH_HEIGHT])
  );

  target_slew_channel #(.STEP(ATT_STEP)) u_pitch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (target_renew),
    .load_val   (target_pitch),
    .force_zero (wd_expire),
    .tick       (tick),
    .sp         (sp_pitch),
    .at_goal    (at_goal[CH_PITCH])
  );

  target_slew_channel #(.STEP(ATT_STEP)) u_roll (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (target_renew),
    .load_val   (target_roll),
    .force_zero (wd_expire),
    .tick       (tick),
    .sp         (sp_roll),
    .at_goal    (at_goal[CH_ROLL])
  );

  target_slew_channel #(.STEP(ATT_STEP)) u_yaw (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (target_renew),
    .load_val   (target_yaw),
    .force_zero (wd_expire),
    .tick       (tick),
    .sp         (sp_yaw),
    .at_goal    (at_goal[CH_YAW])
  );

endmodule

// File: tb/tb_target_slew_limiter.sv
// Bench for target_slew_limiter: integer reference model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_target_slew_limiter;

  localparam int TD = 10;
  localparam int AS = 64;
  localparam int HS = 16;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic target_renew;
  logic signed [15:0] target_height, target_pitch, target_roll, target_yaw;
  logic sp_valid, failsafe, sp_settled;
  logic signed [15:0] sp_height, sp_pitch, sp_roll, sp_yaw;

  int total = 0;
  int bad = 0;
  bit check_en = 0;

  // reference model state (index 0 height, 1 pitch, 2 roll, 3 yaw)
  int m_goal[4];
  int m_sp[4];
  int m_wd, m_cyc;
  bit m_fs, m_valid, m_settled, m_tick;
  int tgt[4];

  target_slew_limiter #(
    .TICK_DIV(TD), .ATT_STEP(AS), .HGT_STEP(HS), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .target_renew(target_renew),
    .target_height(target_height), .target_pitch(target_pitch),
    .target_roll(target_roll), .target_yaw(target_yaw),
    .sp_valid(sp_valid), .sp_height(sp_height), .sp_pitch(sp_pitch),
    .sp_roll(sp_roll), .sp_yaw(sp_yaw), .failsafe(failsafe), .sp_settled(sp_settled)
  );

  always #5 clk = ~clk;

  function automatic int step_of(input int ch);
    return (ch == 0) ? HS : AS;
  endfunction

  // Move cur toward goal by at most s.
  function automatic int move_toward(input int cur, input int goal, input int s);
    int d;
    d = goal - cur;
    if (d <= s && d >= -s) return goal;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated on each rising edge from the inputs held there.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin m_goal[c] = 0; m_sp[c] = 0; end
      m_wd = 0; m_cyc = 0; m_fs = 0; m_valid = 0; m_settled = 1;
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc  = m_cyc + 1;
      if (m_tick)
        for (int c = 0; c < 4; c++) m_sp[c] = move_toward(m_sp[c], m_goal[c], step_of(c));
      tgt[0] = int'(target_height); tgt[1] = int'(target_pitch);
      tgt[2] = int'(target_roll);   tgt[3] = int'(target_yaw);
      if (target_renew) begin
        for (int c = 0; c < 4; c++) m_goal[c] = tgt[c];
        m_wd = 0; m_fs = 0;
      end else if (m_tick && m_wd < TO) begin
        m_wd = m_wd + 1;
        if (m_wd == TO) begin
          m_fs = 1;
          for (int c = 0; c < 4; c++) m_goal[c] = 0;
        end
      end
      m_valid   = m_tick;
      m_settled = 1;
      for (int c = 0; c < 4; c++) if (m_sp[c] != m_goal[c]) m_settled = 0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("model sp_valid",   int'(sp_valid),   int'(m_valid));
      check("model failsafe",   int'(failsafe),   int'(m_fs));
      check("model sp_settled", int'(sp_settled), int'(m_settled));
      check("model sp_height",  int'(sp_height),  m_sp[0]);
      check("model sp_pitch",   int'(sp_pitch),   m_sp[1]);
      check("model sp_roll",    int'(sp_roll),    m_sp[2]);
      check("model sp_yaw",     int'(sp_yaw),     m_sp[3]);
    end
  end

  task automatic wait_valid();
    bit got;
    got = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (sp_valid === 1'b1) begin got = 1; break; end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wait_valid: no sp_valid within %0d cycles", 3 * TD);
    end
  endtask

  task automatic renew(input int h, input int p, input int r, input int y);
    target_height = 16'(h); target_pitch = 16'(p);
    target_roll   = 16'(r); target_yaw   = 16'(y);
    target_renew  = 1'b1;
    @(negedge clk);
    target_renew  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n;
  int exp_p[4];
  int exp_h[3];
  bit found;

  initial begin
    rst_n = 1'b0; target_renew = 1'b0;
    target_height = '0; target_pitch = '0; target_roll = '0; target_yaw = '0;
    repeat (3) @(negedge clk);
    check_en = 1;

    // 1: reset state and tick timing
    check("reset sp_pitch", int'(sp_pitch), 0);
    check("reset sp_settled", int'(sp_settled), 1);
    check("reset failsafe", int'(failsafe), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * TD; i++) begin
      @(negedge clk);
      check($sformatf("first valid cycle %0d", i), int'(sp_valid), (i == TD || i == 2 * TD) ? 1 : 0);
    end

    // 2: basic ramp
    renew(40, 200, -100, 0);
    exp_p = '{64, 128, 192, 200};
    exp_h = '{16, 32, 40};
    for (int k = 0; k < 4; k++) begin
      wait_valid();
      check($sformatf("ramp pitch %0d", k + 1), int'(sp_pitch), exp_p[k]);
      if (k < 3) check($sformatf("ramp height %0d", k + 1), int'(sp_height), exp_h[k]);
      check($sformatf("ramp roll %0d", k + 1), int'(sp_roll), (k == 0) ? -64 : -100);
      check($sformatf("ramp settled %0d", k + 1), int'(sp_settled), (k == 3) ? 1 : 0);
    end

    // 3: renew coincident with a tick
    do_reset();
    found = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if ((m_cyc % TD) == TD - 1) begin found = 1; break; end
    end
    check("align to tick", int'(found), 1);
    renew(0, 64, 0, 0);
    check("coincident valid", int'(sp_valid), 1);
    check("coincident pitch old", int'(sp_pitch), 0);
    wait_valid();
    check("coincident pitch new", int'(sp_pitch), 64);

    // 4: full-scale yaw swing
    do_reset();
    renew(0, 0, 0, -32768);
    n = 0;
    while (int'(sp_yaw) != -32768 && n < 600) begin
      wait_valid(); n++;
      if (n % 10 == 0) renew(0, 0, 0, -32768);
    end
    check("yaw to min ticks", n, 512);
    renew(0, 0, 0, 32767);
    n = 0;
    while (int'(sp_yaw) != 32767 && n < 1100) begin
      wait_valid(); n++;
      if (n == 1) check("yaw first step", int'(sp_yaw), -32768 + 64);
      if (n % 10 == 0) renew(0, 0, 0, 32767);
    end
    check("yaw to max ticks", n, 1024);

    // 5: link timeout
    do_reset();
    wait_valid();
    renew(40, 200, 0, 0);
    exp_p = '{136, 72, 8, 0};
    exp_h = '{24, 8, 0};
    for (int k = 1; k <= 24; k++) begin
      wait_valid();
      if (k == 19) check("failsafe before 20th tick", int'(failsafe), 0);
      if (k == 20) check("failsafe at 20th tick", int'(failsafe), 1);
      if (k == 20) check("pitch held at 20th tick", int'(sp_pitch), 200);
      if (k >= 21) check($sformatf("descend pitch %0d", k), int'(sp_pitch), exp_p[k - 21]);
      if (k >= 21 && k <= 23) check($sformatf("descend height %0d", k), int'(sp_height), exp_h[k - 21]);
    end

    // 6: recovery, renew racing the timeout, reset mid-ramp
    renew(0, 0, 50, 0);
    check("failsafe cleared", int'(failsafe), 0);
    wait_valid();
    check("roll recovered", int'(sp_roll), 50);
    found = 0;
    for (int i = 0; i < 30 * TD; i++) begin
      @(negedge clk);
      if (m_wd == TO - 1 && (m_cyc % TD) == TD - 1) begin found = 1; break; end
    end
    check("align to timeout tick", int'(found), 1);
    renew(0, 0, 50, 0);
    check("renew beats timeout", int'(failsafe), 0);
    wait_valid();
    check("still no failsafe", int'(failsafe), 0);
    renew(0, 1000, 0, 0);
    wait_valid(); wait_valid();
    rst_n = 1'b0;
    @(negedge clk);
    check("midramp reset pitch", int'(sp_pitch), 0);
    check("midramp reset valid", int'(sp_valid), 0);
    check("midramp reset settled", int'(sp_settled), 1);
    rst_n = 1'b1;

    // randomized commands, occasional link loss and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        if ($urandom_range(0, 3) == 0)
          renew(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                int'($signed(16'($urandom))), int'($signed(16'($urandom))));
        else
          renew(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300,
                int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300);
      end else if ($urandom_range(0, 2999) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
